// File: rtl/sha256_block_controller.sv
// SHA-256 block sequencer: accepts one 512-bit block, runs LOAD / 64 ROUNDs / UPDATE,
// and raises a digest handshake after the final block of a message.
module sha256_block_controller #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  input  logic         abort,
  output logic [511:0] sched_data,
  output logic         sched_init,
  output logic [5:0]   sched_index,
  output logic         round_en,
  output logic [31:0]  k_out,
  output logic         work_load,
  output logic         iv_sel,
  output logic         hash_update,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_UPDATE,
    S_OUT
  } state_e;

  localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

  state_e       state_q, state_d;
  logic [5:0]   rcnt_q, rcnt_d;
  logic [511:0] sched_data_q;
  logic         first_q, last_q;
  logic         accept;

  // FIPS 180-4 round constants: first 32 bits of the fractional parts of the
  // cube roots of the first 64 primes.
  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    logic [31:0] k;
    case (idx)
      6'd0:  k = 32'h428a2f98;
      6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;
      6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;
      6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;
      6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;
      6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;
      6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;
      6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;
      6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;
      6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;
      6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;
      6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;
      6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;
      6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;
      6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;
      6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;
      6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;
      6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;
      6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;
      6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;
      6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;
      6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;
      6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;
      6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;
      6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;
      6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;
      6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;
      6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;
      6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;
      6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;
      6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;
      6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;
      default: k = 32'hc67178f2;
    endcase
    return k;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rcnt_q       <= '0;
      sched_data_q <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      if (accept) begin
        sched_data_q <= blk_data;
        first_q      <= blk_first;
        last_q       <= blk_last;
      end
    end
  end

  // Abort wins over every transition, including an accept in IDLE.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    accept  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (blk_valid) begin
            accept  = 1'b1;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          rcnt_d  = '0;
          state_d = S_ROUND;
        end
        S_ROUND: begin
          if (rcnt_q == LAST_RND) begin
            rcnt_d  = '0;
            state_d = S_UPDATE;
          end else begin
            rcnt_d = rcnt_q + 6'd1;
          end
        end
        S_UPDATE: state_d = last_q ? S_OUT : S_IDLE;
        S_OUT: begin
          if (digest_ready) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  // All strobes decode from registered state so async reset clears them at once.
  always_comb begin
    blk_ready    = (state_q == S_IDLE);
    busy         = (state_q != S_IDLE);
    sched_init   = (state_q == S_LOAD);
    work_load    = (state_q == S_LOAD);
    iv_sel       = (state_q == S_LOAD) && first_q;
    round_en     = (state_q == S_ROUND);
    sched_index  = (state_q == S_ROUND) ? rcnt_q : 6'd0;
    k_out        = (state_q == S_ROUND) ? k_rom(rcnt_q) : 32'd0;
    hash_update  = (state_q == S_UPDATE);
    digest_valid = (state_q == S_OUT);
  end

  assign sched_data = sched_data_q;

endmodule

// File: tb/tb_sha256_block_controller.sv
// Directed bench for sha256_block_controller: reset, single block, two-block
// message, digest backpressure, abort and asynchronous reset mid-round.
module tb_sha256_block_controller;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_first = 1'b0;
  logic         blk_last = 1'b0;
  logic         abort = 1'b0;
  logic [511:0] sched_data;
  logic         sched_init;
  logic [5:0]   sched_index;
  logic         round_en;
  logic [31:0]  k_out;
  logic         work_load;
  logic         iv_sel;
  logic         hash_update;
  logic         digest_valid;
  logic         digest_ready = 1'b0;
  logic         busy;

  int n_checks = 0;
  int n_pass = 0;

  logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [511:0] hello;

  sha256_block_controller #(.ROUNDS(64)) dut (
    .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last), .abort(abort),
    .sched_data(sched_data), .sched_init(sched_init), .sched_index(sched_index),
    .round_en(round_en), .k_out(k_out), .work_load(work_load), .iv_sel(iv_sel),
    .hash_update(hash_update), .digest_valid(digest_valid), .digest_ready(digest_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Offers a block in IDLE; returns in cycle 1 (LOAD) with blk_valid dropped.
  task automatic accept(input logic [511:0] d, input logic f, input logic l);
    blk_data  = d;
    blk_first = f;
    blk_last  = l;
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [50:0] obs;
    reset = 1'b1;
    advance(2);
    obs = {blk_ready, busy, sched_init, round_en, work_load, iv_sel, hash_update,
           digest_valid, sched_index, k_out, 5'd0};
    n_checks++;
    if (obs !== {1'b1, 1'b0, 6'd0, 6'd0, 32'd0, 5'd0})
      $display("FAIL reset_outputs: got %h expected %h", obs, {1'b1, 1'b0, 6'd0, 6'd0, 32'd0, 5'd0});
    else n_pass++;
    n_checks++;
    if (sched_data !== 512'd0) $display("FAIL reset_sched_data: got %h expected 0", sched_data);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    step();
    n_checks++;
    if ({blk_ready, busy} !== 2'b10) $display("FAIL reset_release_idle: got %b expected 10", {blk_ready, busy});
    else n_pass++;
  endtask

  task automatic test_hello();
    logic [40:0] obs;
    hello = '0;
    hello[511:464] = 48'h68656c6c6f80;
    hello[7:0] = 8'h28;
    accept(hello, 1'b1, 1'b1);
    n_checks++;
    if ({sched_init, work_load, iv_sel, round_en, busy, sched_index, k_out} !== {5'b11101, 6'd0, 32'd0})
      $display("FAIL hello_load: got %h expected %h",
               {sched_init, work_load, iv_sel, round_en, busy, sched_index, k_out}, {5'b11101, 6'd0, 32'd0});
    else n_pass++;
    n_checks++;
    if ({sched_data[511:480], sched_data[479:448], sched_data[31:0]} !== {32'h68656c6c, 32'h6f800000, 32'h00000028})
      $display("FAIL hello_words: got %h expected 68656c6c6f80000000000028",
               {sched_data[511:480], sched_data[479:448], sched_data[31:0]});
    else n_pass++;
    for (int t = 0; t < 64; t++) begin
      step();
      obs = {round_en, sched_index, k_out, sched_init, hash_update};
      n_checks++;
      if (obs !== {1'b1, 6'(t), K[t], 2'b00})
        $display("FAIL hello_round%0d: got %h expected %h", t, obs, {1'b1, 6'(t), K[t], 2'b00});
      else n_pass++;
    end
    step();
    n_checks++;
    if ({hash_update, round_en, digest_valid, sched_index, k_out} !== {3'b100, 6'd0, 32'd0})
      $display("FAIL hello_update: got %h expected %h",
               {hash_update, round_en, digest_valid, sched_index, k_out}, {3'b100, 6'd0, 32'd0});
    else n_pass++;
    n_checks++;
    if (sched_data !== hello) $display("FAIL hello_data_stable: got %h expected %h", sched_data, hello);
    else n_pass++;
    step();
    n_checks++;
    if ({digest_valid, blk_ready, hash_update} !== 3'b100)
      $display("FAIL hello_digest: got %b expected 100", {digest_valid, blk_ready, hash_update});
    else n_pass++;
  endtask

  // Continues from test_hello with the DUT sitting in OUT.
  task automatic test_backpressure();
    digest_ready = 1'b0;
    blk_data = {16{32'hdeadbeef}};
    blk_first = 1'b1;
    blk_last = 1'b1;
    blk_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if ({digest_valid, blk_ready, busy} !== 3'b101)
        $display("FAIL bp_hold%0d: got %b expected 101", i, {digest_valid, blk_ready, busy});
      else n_pass++;
    end
    digest_ready = 1'b1;
    step();
    blk_valid = 1'b0;
    digest_ready = 1'b0;
    n_checks++;
    if ({digest_valid, blk_ready, busy} !== 3'b010)
      $display("FAIL bp_release: got %b expected 010", {digest_valid, blk_ready, busy});
    else n_pass++;
    n_checks++;
    if (sched_data !== hello) $display("FAIL bp_no_capture: got %h expected %h", sched_data, hello);
    else n_pass++;
  endtask

  task automatic test_two_block();
    logic [511:0] a, b;
    a = {16{32'ha5a50001}};
    b = {16{32'h3c3c0002}};
    accept(a, 1'b1, 1'b0);
    n_checks++;
    if ({sched_init, iv_sel} !== 2'b11) $display("FAIL two_a_load: got %b expected 11", {sched_init, iv_sel});
    else n_pass++;
    advance(64);
    n_checks++;
    if ({round_en, sched_index} !== {1'b1, 6'd63})
      $display("FAIL two_a_last_round: got %h expected %h", {round_en, sched_index}, {1'b1, 6'd63});
    else n_pass++;
    step();
    n_checks++;
    if (hash_update !== 1'b1) $display("FAIL two_a_update: got %b expected 1", hash_update);
    else n_pass++;
    step();
    n_checks++;
    if ({digest_valid, blk_ready} !== 2'b01)
      $display("FAIL two_a_no_digest: got %b expected 01", {digest_valid, blk_ready});
    else n_pass++;
    accept(b, 1'b0, 1'b1);
    n_checks++;
    if ({sched_init, work_load, iv_sel} !== 3'b110)
      $display("FAIL two_b_load: got %b expected 110", {sched_init, work_load, iv_sel});
    else n_pass++;
    n_checks++;
    if (sched_data !== b) $display("FAIL two_b_data: got %h expected %h", sched_data, b);
    else n_pass++;
    digest_ready = 1'b1;
    advance(65);
    n_checks++;
    if ({hash_update, digest_valid} !== 2'b10)
      $display("FAIL two_b_update: got %b expected 10", {hash_update, digest_valid});
    else n_pass++;
    step();
    n_checks++;
    if (digest_valid !== 1'b1) $display("FAIL two_b_digest: got %b expected 1", digest_valid);
    else n_pass++;
    step();
    digest_ready = 1'b0;
    n_checks++;
    if ({digest_valid, blk_ready} !== 2'b01)
      $display("FAIL two_b_one_cycle_out: got %b expected 01", {digest_valid, blk_ready});
    else n_pass++;
  endtask

  task automatic test_abort();
    accept({16{32'h11223344}}, 1'b1, 1'b1);
    advance(31);
    n_checks++;
    if ({round_en, sched_index} !== {1'b1, 6'd30})
      $display("FAIL abort_at30: got %h expected %h", {round_en, sched_index}, {1'b1, 6'd30});
    else n_pass++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if ({blk_ready, busy, round_en, hash_update} !== 4'b1000)
      $display("FAIL abort_idle: got %b expected 1000", {blk_ready, busy, round_en, hash_update});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({hash_update, busy} !== 2'b00)
        $display("FAIL abort_quiet%0d: got %b expected 00", i, {hash_update, busy});
      else n_pass++;
    end
    accept({16{32'h55667788}}, 1'b0, 1'b1);
    n_checks++;
    if ({sched_init, iv_sel} !== 2'b10) $display("FAIL abort_new_load: got %b expected 10", {sched_init, iv_sel});
    else n_pass++;
    step();
    n_checks++;
    if ({round_en, sched_index, k_out} !== {1'b1, 6'd0, K[0]})
      $display("FAIL abort_new_round0: got %h expected %h", {round_en, sched_index, k_out}, {1'b1, 6'd0, K[0]});
    else n_pass++;
    advance(63);
    n_checks++;
    if ({round_en, sched_index, k_out} !== {1'b1, 6'd63, K[63]})
      $display("FAIL abort_new_round63: got %h expected %h", {round_en, sched_index, k_out}, {1'b1, 6'd63, K[63]});
    else n_pass++;
    step();
    n_checks++;
    if (hash_update !== 1'b1) $display("FAIL abort_new_update: got %b expected 1", hash_update);
    else n_pass++;
    step();
    n_checks++;
    if (digest_valid !== 1'b1) $display("FAIL abort_new_digest: got %b expected 1", digest_valid);
    else n_pass++;
    digest_ready = 1'b1;
    abort = 1'b1;
    step();
    digest_ready = 1'b0;
    abort = 1'b0;
    n_checks++;
    if ({digest_valid, blk_ready} !== 2'b01)
      $display("FAIL abort_with_ready: got %b expected 01", {digest_valid, blk_ready});
    else n_pass++;
  endtask

  task automatic test_reset_mid_round();
    accept({16{32'hcafef00d}}, 1'b0, 1'b0);
    advance(21);
    n_checks++;
    if ({round_en, sched_index, k_out} !== {1'b1, 6'd20, K[20]})
      $display("FAIL rst_at20: got %h expected %h", {round_en, sched_index, k_out}, {1'b1, 6'd20, K[20]});
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({round_en, hash_update, busy, sched_index, k_out} !== {3'b000, 6'd0, 32'd0})
      $display("FAIL rst_async: got %h expected %h",
               {round_en, hash_update, busy, sched_index, k_out}, {3'b000, 6'd0, 32'd0});
    else n_pass++;
    n_checks++;
    if (sched_data !== 512'd0) $display("FAIL rst_async_data: got %h expected 0", sched_data);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    step();
    n_checks++;
    if ({blk_ready, busy, hash_update, sched_init} !== 4'b1000)
      $display("FAIL rst_release: got %b expected 1000", {blk_ready, busy, hash_update, sched_init});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_hello();
    test_backpressure();
    test_two_block();
    test_abort();
    test_reset_mid_round();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
